// File: rtl/pe_mac_stream.sv
// pe_mac_stream: systolic PE that forwards operands and accumulates a*b per tile into a ready/valid result port.
//   clk_i, reset_i          clock, async active-high reset
//   en_i, clr_i             global advance, sync clear of acc/tile-ovf/overrun
//   in_valid_i, in_last_i   beat framing; in_a_i/in_b_i operands
//   out_*_o                 operands/framing forwarded with 1-cycle latency
//   res_valid_o/res_ready_i result handshake; res_data_o tile sum, res_ovf_o tile overflowed
//   overrun_o               sticky: a finished tile was dropped
module pe_mac_stream #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 2*DATA_W+4,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic              in_valid_i,
    input  logic              in_last_i,
    input  logic [DATA_W-1:0] in_a_i,
    input  logic [DATA_W-1:0] in_b_i,
    output logic              out_valid_o,
    output logic              out_last_o,
    output logic [DATA_W-1:0] out_a_o,
    output logic [DATA_W-1:0] out_b_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [ACC_W-1:0]  res_data_o,
    output logic              res_ovf_o,
    output logic              overrun_o
);
    localparam int XW = ACC_W + 1;
    localparam bit SG = (SIGNED != 0);
    localparam bit ST = (SATURATE != 0);
    logic [XW-1:0] a_x, b_x, acc_x, prod, sum;
    logic [ACC_W-1:0] acc_q, acc_d, acc_nx, sat_val, res_data_d;
    logic tovf_q, tovf_d, ovf, beat, done, load;
    logic res_valid_d, res_ovf_d, overrun_d;
    // Operands and accumulator are widened one bit past ACC_W so the sum's
    // extra bit exposes overflow; the truncated product is exact because
    // ACC_W >= 2*DATA_W.
    assign a_x   = {{(XW-DATA_W){SG & in_a_i[DATA_W-1]}}, in_a_i};
    assign b_x   = {{(XW-DATA_W){SG & in_b_i[DATA_W-1]}}, in_b_i};
    assign acc_x = {SG & acc_q[ACC_W-1], acc_q};
    assign prod  = a_x * b_x;
    assign sum   = acc_x + prod;
    // Signed: top two bits disagree on overflow, sum[ACC_W] gives direction.
    // Unsigned: operands are non-negative, so only a carry out can occur.
    assign ovf     = SG ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
    assign sat_val = !SG ? {ACC_W{1'b1}} :
                     sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    assign acc_nx  = (ovf && ST) ? sat_val : sum[ACC_W-1:0];
    assign beat = en_i & in_valid_i & ~clr_i;
    assign done = beat & in_last_i;
    // A finished tile loads only if the slot is empty or being drained this edge.
    assign load = done & (~res_valid_o | res_ready_i);
    always_comb begin
        acc_d       = clr_i ? '0 : beat ? (in_last_i ? '0 : acc_nx) : acc_q;
        tovf_d      = clr_i ? 1'b0 : beat ? (~in_last_i & (tovf_q | ovf)) : tovf_q;
        res_valid_d = load | (res_valid_o & ~res_ready_i);
        res_data_d  = load ? acc_nx : res_data_o;
        res_ovf_d   = load ? (tovf_q | ovf) : res_ovf_o;
        overrun_d   = ~clr_i & (overrun_o | (done & res_valid_o & ~res_ready_i));
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            out_a_o     <= '0;
            out_b_o     <= '0;
            acc_q       <= '0;
            tovf_q      <= 1'b0;
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
            res_ovf_o   <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (en_i) begin
                out_valid_o <= in_valid_i;
                out_last_o  <= in_last_i;
                out_a_o     <= in_a_i;
                out_b_o     <= in_b_i;
            end
            acc_q       <= acc_d;
            tovf_q      <= tovf_d;
            res_valid_o <= res_valid_d;
            res_data_o  <= res_data_d;
            res_ovf_o   <= res_ovf_d;
            overrun_o   <= overrun_d;
        end
    end
endmodule
